// File: rtl/cbus_wide_master.sv
// CBUS initiator: carries one host access of up to 64 bits as one or two 32-bit CBUS beats.
// Optional request timeout compiled in with `define CBUS_WIDE_MASTER_TIMEOUT_EN.
module cbus_wide_master #(
    parameter int unsigned DW   = 64,
    parameter int unsigned AW   = 10,
    parameter int unsigned TO_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          host_valid,
    output logic          host_ready,
    input  logic          host_cmd,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_done,
    output logic [DW-1:0] host_rdata,
    output logic          host_err,
    output logic          cbus_req,
    output logic          cbus_slv_cmd,
    output logic [AW:0]   cbus_slv_address,
    output logic [31:0]   cbus_slv_wdata,
    input  logic          cbus_waccept,
    input  logic          cbus_rresp,
    input  logic [31:0]   cbus_rddata
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StReqLo = 3'd1;
    localparam logic [2:0] StGap   = 3'd2;
    localparam logic [2:0] StReqHi = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    localparam bit TwoBeat = (DW > 32);

    logic [2:0]    state_q, state_d;
    logic          req_q, req_d;
    logic          cmd_q, cmd_d;
    logic [AW:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   wdata_hi_q, wdata_hi_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [63:0]   wdata_in_ext;
    logic [63:0]   rdata_ext;
    logic          resp;
    logic          timeout;

    // Bits above DW are zero in the extended views; only part of them is consumed.
    logic unused_ext;
    assign unused_ext = ^{rdata_ext, wdata_in_ext};

    assign wdata_in_ext = 64'(host_wdata);
    assign resp = req_q && (cmd_q ? cbus_waccept : cbus_rresp);

`ifdef CBUS_WIDE_MASTER_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            req_entry;

    assign timeout   = req_q && !resp && (to_cnt_q == {TO_W{1'b1}});
    assign req_entry = (state_d != state_q) && ((state_d == StReqLo) || (state_d == StReqHi));

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (req_entry) begin
            to_cnt_d = '0;
        end else if (req_q && !resp) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    logic unused_to_w;
    assign unused_to_w = (TO_W == 0);
    assign timeout     = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wdata_hi_d = wdata_hi_q;
        err_d      = err_q;
        rdata_ext  = 64'(rdata_q);

        case (state_q)
            StIdle: begin
                if (host_valid) begin
                    state_d    = StReqLo;
                    req_d      = 1'b1;
                    cmd_d      = host_cmd;
                    addr_d     = {host_addr, 1'b0};
                    wdata_d    = wdata_in_ext[31:0];
                    wdata_hi_d = wdata_in_ext[63:32];
                    err_d      = 1'b0;
                    rdata_ext  = '0;
                end
            end
            StReqLo: begin
                if (resp) begin
                    req_d   = 1'b0;
                    state_d = TwoBeat ? StGap : StDone;
                    if (!cmd_q) begin
                        rdata_ext[31:0] = cbus_rddata;
                    end
                end else if (timeout) begin
                    req_d     = 1'b0;
                    state_d   = StDone;
                    err_d     = 1'b1;
                    rdata_ext = '0;
                end
            end
            StGap: begin
                state_d = StReqHi;
                req_d   = 1'b1;
                addr_d  = {addr_q[AW:1], 1'b1};
                wdata_d = wdata_hi_q;
            end
            StReqHi: begin
                if (resp) begin
                    req_d   = 1'b0;
                    state_d = StDone;
                    if (!cmd_q) begin
                        rdata_ext[63:32] = cbus_rddata;
                    end
                end else if (timeout) begin
                    req_d     = 1'b0;
                    state_d   = StDone;
                    err_d     = 1'b1;
                    rdata_ext = '0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
            end
        endcase

        rdata_d = DW'(rdata_ext);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            cmd_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wdata_hi_q <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wdata_hi_q <= wdata_hi_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign host_ready       = (state_q == StIdle);
    assign host_done        = (state_q == StDone);
    assign host_rdata       = rdata_q;
    assign host_err         = err_q;
    assign cbus_req         = req_q;
    assign cbus_slv_cmd     = cmd_q;
    assign cbus_slv_address = addr_q;
    assign cbus_slv_wdata   = wdata_q;

endmodule

// File: tb/tb_cbus_wide_master.sv
// Directed bench for cbus_wide_master: a DW=64 and a DW=24 instance share the CBUS response inputs.
module tb_cbus_wide_master;

    logic        clk;
    logic        reset;
    logic        cmd;
    logic [9:0]  addr;
    logic        waccept;
    logic        rresp;
    logic [31:0] rddata;

    logic        v64, rdy64, done64, err64, req64, scmd64;
    logic [63:0] wd64, rd64;
    logic [10:0] sadr64;
    logic [31:0] swd64;

    logic        v24, rdy24, done24, err24, req24, scmd24;
    logic [23:0] wd24, rd24;
    logic [10:0] sadr24;
    logic [31:0] swd24;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    cbus_wide_master #(.DW(64), .AW(10), .TO_W(4)) u_dut64 (
        .clk              (clk),
        .reset            (reset),
        .host_valid       (v64),
        .host_ready       (rdy64),
        .host_cmd         (cmd),
        .host_addr        (addr),
        .host_wdata       (wd64),
        .host_done        (done64),
        .host_rdata       (rd64),
        .host_err         (err64),
        .cbus_req         (req64),
        .cbus_slv_cmd     (scmd64),
        .cbus_slv_address (sadr64),
        .cbus_slv_wdata   (swd64),
        .cbus_waccept     (waccept),
        .cbus_rresp       (rresp),
        .cbus_rddata      (rddata)
    );

    cbus_wide_master #(.DW(24), .AW(10), .TO_W(4)) u_dut24 (
        .clk              (clk),
        .reset            (reset),
        .host_valid       (v24),
        .host_ready       (rdy24),
        .host_cmd         (cmd),
        .host_addr        (addr),
        .host_wdata       (wd24),
        .host_done        (done24),
        .host_rdata       (rd24),
        .host_err         (err24),
        .cbus_req         (req24),
        .cbus_slv_cmd     (scmd24),
        .cbus_slv_address (sadr24),
        .cbus_slv_wdata   (swd24),
        .cbus_waccept     (waccept),
        .cbus_rresp       (rresp),
        .cbus_rddata      (rddata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; cmd = 1'b0; addr = '0; waccept = 1'b0; rresp = 1'b0; rddata = '0;
        v64 = 1'b0; wd64 = '0; v24 = 1'b0; wd24 = '0;
        nxt();
        nxt();
        chk("rst_ready", 64'(rdy64), 64'd1);
        chk("rst_req", 64'(req64), 64'd0);
        chk("rst_done", 64'(done64), 64'd0);
        chk("rst_addr", 64'(sadr64), 64'd0);
        chk("rst_rdata", rd64, 64'd0);
        reset = 1'b0;
        nxt();

        // DW=64 write, slave accepts immediately
        chk("w64_ready", 64'(rdy64), 64'd1);
        v64 = 1'b1; cmd = 1'b1; addr = 10'h012; wd64 = 64'hAABBCCDD_11223344;
        nxt();                                           // T+1
        v64 = 1'b0;
        chk("w64_lo_req", 64'(req64), 64'd1);
        chk("w64_lo_cmd", 64'(scmd64), 64'd1);
        chk("w64_lo_addr", 64'(sadr64), 64'h024);
        chk("w64_lo_wdata", 64'(swd64), 64'h11223344);
        waccept = 1'b1;
        nxt();                                           // T+2
        waccept = 1'b0;
        chk("w64_gap_req", 64'(req64), 64'd0);
        nxt();                                           // T+3
        chk("w64_hi_req", 64'(req64), 64'd1);
        chk("w64_hi_addr", 64'(sadr64), 64'h025);
        chk("w64_hi_wdata", 64'(swd64), 64'hAABBCCDD);
        waccept = 1'b1;
        nxt();                                           // T+4
        waccept = 1'b0;
        chk("w64_done", 64'(done64), 64'd1);
        chk("w64_err", 64'(err64), 64'd0);
        chk("w64_rdata", rd64, 64'd0);
        chk("w64_req_off", 64'(req64), 64'd0);
        nxt();                                           // T+5
        chk("w64_ready_back", 64'(rdy64), 64'd1);
        chk("w64_done_off", 64'(done64), 64'd0);

        // DW=64 read back-to-back, two wait cycles per beat, wrong-type accept ignored
        v64 = 1'b1; cmd = 1'b0; addr = 10'h003;
        nxt();                                           // T+1
        v64 = 1'b0;
        chk("r64_lo_addr", 64'(sadr64), 64'h006);
        chk("r64_lo_cmd", 64'(scmd64), 64'd0);
        waccept = 1'b1;
        nxt();                                           // T+2
        waccept = 1'b0;
        chk("r64_wait_req", 64'(req64), 64'd1);
        nxt();                                           // T+3
        rresp = 1'b1; rddata = 32'h55667788;
        nxt();                                           // T+4
        rresp = 1'b0; rddata = '0;
        chk("r64_gap_req", 64'(req64), 64'd0);
        nxt();                                           // T+5
        chk("r64_hi_req", 64'(req64), 64'd1);
        chk("r64_hi_addr", 64'(sadr64), 64'h007);
        nxt();                                           // T+6
        nxt();                                           // T+7
        chk("r64_hi_done_early", 64'(done64), 64'd0);
        rresp = 1'b1; rddata = 32'h99AABBCC;
        nxt();                                           // T+8
        rresp = 1'b0; rddata = '0;
        chk("r64_done", 64'(done64), 64'd1);
        chk("r64_rdata", rd64, 64'h99AABBCC_55667788);
        nxt();

        // Spurious read response while idle
        rresp = 1'b1; rddata = 32'hFFFF0000;
        nxt();
        rresp = 1'b0; rddata = '0;
        chk("spur_idle_ready", 64'(rdy64), 64'd1);
        chk("spur_idle_req", 64'(req64), 64'd0);
        chk("spur_idle_done24", 64'(done24), 64'd0);
        nxt();
        chk("spur_idle_done", 64'(done64), 64'd0);

        // DW=24 write, single beat
        v24 = 1'b1; cmd = 1'b1; addr = 10'h007; wd24 = 24'hABCDEF;
        nxt();                                           // T+1
        v24 = 1'b0;
        chk("w24_addr", 64'(sadr24), 64'h00E);
        chk("w24_wdata", 64'(swd24), 64'h00ABCDEF);
        waccept = 1'b1;
        nxt();                                           // T+2
        waccept = 1'b0;
        chk("w24_done", 64'(done24), 64'd1);
        chk("w24_done_64idle", 64'(done64), 64'd0);
        nxt();

        // DW=24 read: upper byte of the beat is dropped
        v24 = 1'b1; cmd = 1'b0; addr = 10'h001;
        nxt();
        v24 = 1'b0;
        rresp = 1'b1; rddata = 32'h12345678;
        nxt();
        rresp = 1'b0; rddata = '0;
        chk("r24_done", 64'(done24), 64'd1);
        chk("r24_rdata", 64'(rd24), 64'h345678);
        nxt();

        // DW=24 write with a read response during the beat
        v24 = 1'b1; cmd = 1'b1; addr = 10'h002; wd24 = 24'h000155;
        nxt();                                           // T+1
        v24 = 1'b0;
        rresp = 1'b1;
        nxt();                                           // T+2
        rresp = 1'b0;
        chk("w24_rresp_req", 64'(req24), 64'd1);
        chk("w24_rresp_done", 64'(done24), 64'd0);
        waccept = 1'b1;
        nxt();                                           // T+3
        waccept = 1'b0;
        chk("w24_late_done", 64'(done24), 64'd1);
        nxt();

        // Reset pulsed during the read GAP, after the low half was captured
        v64 = 1'b1; cmd = 1'b0; addr = 10'h03F;
        nxt();                                           // T+1
        v64 = 1'b0;
        chk("rg_lo_addr", 64'(sadr64), 64'h07E);
        rresp = 1'b1; rddata = 32'hDEADBEEF;
        nxt();                                           // T+2 GAP
        rresp = 1'b0; rddata = '0;
        reset = 1'b1;
        #1;
        chk("rg_ready", 64'(rdy64), 64'd1);
        chk("rg_rdata", rd64, 64'd0);
        chk("rg_addr", 64'(sadr64), 64'd0);
        reset = 1'b0;
        nxt();
        chk("rg_no_done", 64'(done64), 64'd0);
        chk("rg_no_req", 64'(req64), 64'd0);
        nxt();
        chk("rg_no_done2", 64'(done64), 64'd0);
        v64 = 1'b1; cmd = 1'b0; addr = 10'h005;
        nxt();                                           // T+1
        v64 = 1'b0;
        chk("rg_new_addr", 64'(sadr64), 64'h00A);
        rresp = 1'b1; rddata = 32'h00000001;
        nxt();
        rresp = 1'b0;
        nxt();
        rresp = 1'b1; rddata = 32'h00000002;
        nxt();
        rresp = 1'b0; rddata = '0;
        chk("rg_new_done", 64'(done64), 64'd1);
        chk("rg_new_rdata", rd64, 64'h00000002_00000001);
        nxt();

        // Reset while the request is high drops cbus_req at once
        v64 = 1'b1; cmd = 1'b1; addr = 10'h011; wd64 = 64'h1;
        nxt();
        v64 = 1'b0;
        reset = 1'b1;
        #1;
        chk("rq_req_drop", 64'(req64), 64'd0);
        chk("rq_cmd_clr", 64'(scmd64), 64'd0);
        reset = 1'b0;
        nxt();

`ifdef CBUS_WIDE_MASTER_TIMEOUT_EN
        // High beat times out after its low half was read
        v64 = 1'b1; cmd = 1'b0; addr = 10'h002;
        nxt();                                           // T+1
        v64 = 1'b0;
        rresp = 1'b1; rddata = 32'h13579BDF;
        nxt();                                           // T+2
        rresp = 1'b0; rddata = '0;
        nxt();                                           // T+3, count 0
        repeat (15) nxt();                               // T+18, count 15
        chk("to_last_req", 64'(req64), 64'd1);
        chk("to_last_done", 64'(done64), 64'd0);
        nxt();                                           // T+19
        chk("to_done", 64'(done64), 64'd1);
        chk("to_err", 64'(err64), 64'd1);
        chk("to_rdata", rd64, 64'd0);
        chk("to_req", 64'(req64), 64'd0);
        nxt();

        // Response at terminal count wins
        v64 = 1'b1; cmd = 1'b1; addr = 10'h004; wd64 = 64'h2;
        nxt();                                           // T+1
        v64 = 1'b0;
        repeat (15) nxt();                               // T+16, count 15
        chk("tc_req", 64'(req64), 64'd1);
        waccept = 1'b1;
        nxt();                                           // T+17
        waccept = 1'b0;
        chk("tc_gap_done", 64'(done64), 64'd0);
        chk("tc_gap_req", 64'(req64), 64'd0);
        nxt();                                           // T+18
        chk("tc_hi_addr", 64'(sadr64), 64'h009);
        waccept = 1'b1;
        nxt();                                           // T+19
        waccept = 1'b0;
        chk("tc_done", 64'(done64), 64'd1);
        chk("tc_err", 64'(err64), 64'd0);
        nxt();
`else
        // Without a timeout a silent slave is waited on indefinitely
        v64 = 1'b1; cmd = 1'b1; addr = 10'h004; wd64 = 64'h2;
        nxt();                                           // T+1
        v64 = 1'b0;
        repeat (30) nxt();                               // T+31
        chk("nto_req", 64'(req64), 64'd1);
        chk("nto_done", 64'(done64), 64'd0);
        chk("nto_err", 64'(err64), 64'd0);
        waccept = 1'b1;
        nxt();                                           // T+32
        waccept = 1'b0;
        chk("nto_gap", 64'(req64), 64'd0);
        nxt();                                           // T+33
        waccept = 1'b1;
        nxt();                                           // T+34
        waccept = 1'b0;
        chk("nto_done_end", 64'(done64), 64'd1);
        chk("nto_err_end", 64'(err64), 64'd0);
        nxt();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
